apb_slave_mem: RTL and testbench
================================

Name: apb_slave_mem

Overview:
- Parametrised APB4 completer: a word-addressed register memory with programmable wait states, byte-strobe writes, and PSLVERR generation.
- Serves as the configurable downstream target behind the AHB-APB bridge, for both RTL integration and bridge verification.
- Generalises the plain APB signal bundle into a block with data width, depth, base address, wait states and a protection check.
- Adds an error counter.

Parameters:
- PADDR_SIZE, 32, APB address width.
- PDATA_SIZE, 32, APB data width; 8, 16, 32 or 64.
- DEPTH, 16, number of PDATA_SIZE words.
- BASE_ADDR, 0, byte address of word 0; aligned to DEPTH*PDATA_SIZE/8.
- WAIT_W, 4, width of the wait-state config.
- REQ_PRIV, 0, when 1 an access with PPROT[0]=0 is an error.
- ERRCNT_W, 8, width of the error counter.

Ports:
- pclk, in, 1, clock.
- PRESETn, in, 1, reset.
- PSEL, in, 1, select.
- PENABLE, in, 1, access phase.
- PPROT, in, 3, protection.
- PWRITE, in, 1, 1 = write.
- PSTRB, in, PDATA_SIZE/8, write byte lanes.
- PADDR, in, PADDR_SIZE, byte address.
- PWDATA, in, PDATA_SIZE, write data.
- PRDATA, out, PDATA_SIZE, read data.
- PREADY, out, 1, transfer complete.
- PSLVERR, out, 1, error response; valid only with PREADY.
- wait_cfg, in, WAIT_W, wait states inserted per transfer.
- err_cnt, out, ERRCNT_W, saturating count of errored transfers.

Behaviour:
- Single clock pclk. Reset PRESETn is synchronous, active-low.
- Reset values:
  - PREADY=0, PSLVERR=0, PRDATA=0, err_cnt=0, state=IDLE.
  - All memory words cleared to 0.
- Reset mid-transfer aborts the transfer with no write.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - A setup cycle (PSEL=1, PENABLE=0) latches PADDR, PWRITE, PSTRB, PPROT and wait_cfg, and goes to WAIT.
  - PENABLE=1 with no preceding setup is ignored; stay IDLE, no response.
- WAIT:
  - Counter cnt is loaded with wait_cfg at the setup edge.
  - Each cycle with PSEL=1 and PENABLE=1 decrements cnt.
  - PREADY is registered and asserts for exactly one cycle: the (wait_cfg+1)th access cycle.
  - With wait_cfg=0, PREADY is high in the first access cycle, so the transfer takes 2 cycles total.
  - If PSEL falls during WAIT, abort: return to IDLE, no write, err_cnt unchanged.
- DONE (the cycle PREADY=1):
  - PRDATA and PSLVERR are valid in this cycle.
  - Write commits at the closing edge when there is no error.
  - At that edge PREADY, PSLVERR and PRDATA return to 0 and the FSM goes to IDLE.
  - A new setup cycle may follow immediately (back-to-back transfers, no idle cycle required).
- Error determination (evaluated at setup, registered):
  - Address outside [BASE_ADDR, BASE_ADDR+DEPTH*PDATA_SIZE/8).
  - PADDR low log2(PDATA_SIZE/8) bits nonzero.
  - REQ_PRIV=1 and PPROT[0]=0.
- On error:
  - PSLVERR=1 with PREADY, PRDATA=0, memory untouched.
  - err_cnt increments at the DONE edge and saturates at all-ones.
- Writes:
  - Byte lane i is written iff PSTRB[i]=1.
  - PSTRB=0 completes with OKAY and changes nothing.
- Reads:
  - PRDATA = memory word at index (PADDR-BASE_ADDR)>>log2(PDATA_SIZE/8).
  - PSTRB is ignored on reads.
- wait_cfg changes during a transfer do not affect it; the value is sampled at setup only.

Decomposition:
- bridge_pkg (existing) keeps PADDR_SIZE and PDATA_SIZE.
- Add to bridge_pkg:
  - apb_slv_state_e enum {IDLE, WAIT, DONE}.
  - Function addr_in_range(addr, base, depth_bytes).
- One natural sub-module: apb_strb_merge. It is combinational and produces new_word from old_word, PWDATA and PSTRB; it is reused by future APB targets.

Test Plan:
- Write then read, wait_cfg=0: write 0xDEADBEEF to BASE+0x8 with PSTRB=0xF, then read BASE+0x8. Required: each transfer is 2 cycles, PRDATA=0xDEADBEEF, PSLVERR=0.
- Byte strobes: word preloaded to 0x11223344, write 0xAABBCCDD with PSTRB=0b0101, then read. Required: 0x11BB33DD.
- Wait states: wait_cfg=3, read. Required: PREADY low for 3 access cycles and high on the 4th. Change wait_cfg to 0 mid-transfer; required: no effect on the current transfer.
- Errors:
  - Read at BASE+DEPTH*4: PSLVERR=1, PRDATA=0, err_cnt=1.
  - Write at BASE+0x2: PSLVERR=1, memory unchanged, err_cnt=2.
  - With REQ_PRIV=1 and PPROT=0: PSLVERR=1.
- Abort and reset:
  - PSEL dropped in WAIT with wait_cfg=5: no write, no PREADY.
  - PRESETn=0 mid-write: all outputs 0 next cycle, memory reads 0.
- Back-to-back and saturation:
  - Four consecutive transfers with no idle cycle all complete correctly.
  - 300 errors with ERRCNT_W=8: err_cnt=255.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared definitions for the AHB-APB bridge and its APB targets:
// bus widths, completer FSM states and an address window helper.
package bridge_pkg;

  localparam int PADDR_SIZE = 32;
  localparam int PDATA_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } apb_slv_state_e;

  // Half-open window [base, base+depth_bytes); 64-bit so any bus width fits.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input logic [63:0] depth_bytes);
    return (addr >= base) && (addr < base + depth_bytes);
  endfunction

endpackage

// File: rtl/apb_strb_merge.sv
// Byte-lane write merge: lanes with a set strobe take the write data,
// the rest keep the stored word.
module apb_strb_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W/8-1:0] PSTRB,
  output logic [DATA_W-1:0]   new_word
);
  import bridge_pkg::*;

  always_comb begin
    new_word = old_word;
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (PSTRB[i]) new_word[8*i +: 8] = PWDATA[8*i +: 8];
    end
  end

endmodule

// File: rtl/apb_slave_mem.sv
// APB4 completer backed by a word-addressed register memory, with programmable
// wait states, byte-strobe writes, PSLVERR generation and a saturating error counter.
module apb_slave_mem #(
  parameter int                    PADDR_SIZE = bridge_pkg::PADDR_SIZE,
  parameter int                    PDATA_SIZE = bridge_pkg::PDATA_SIZE,
  parameter int                    DEPTH      = 16,
  parameter logic [PADDR_SIZE-1:0] BASE_ADDR  = '0,
  parameter int                    WAIT_W     = 4,
  parameter bit                    REQ_PRIV   = 1'b0,
  parameter int                    ERRCNT_W   = 8
) (
  input  logic                    pclk,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic [2:0]              PPROT,
  input  logic                    PWRITE,
  input  logic [PDATA_SIZE/8-1:0] PSTRB,
  input  logic [PADDR_SIZE-1:0]   PADDR,
  input  logic [PDATA_SIZE-1:0]   PWDATA,
  output logic [PDATA_SIZE-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  input  logic [WAIT_W-1:0]       wait_cfg,
  output logic [ERRCNT_W-1:0]     err_cnt
);
  import bridge_pkg::*;

  localparam int STRB_W = PDATA_SIZE / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] SPAN = 64'(DEPTH) * 64'(STRB_W);
  localparam logic [PADDR_SIZE-1:0] ALIGN_MASK = PADDR_SIZE'((64'd1 << LSB) - 64'd1);

  apb_slv_state_e state, state_next;
  logic [WAIT_W-1:0]     cnt;
  logic [IDX_W-1:0]      idx_r;
  logic                  write_r;
  logic [STRB_W-1:0]     strb_r;
  logic                  err_r;
  logic [PDATA_SIZE-1:0] mem [DEPTH];

  logic [PADDR_SIZE-1:0] offset;
  logic [IDX_W-1:0]      idx_now, idx_sel;
  logic                  err_now, err_sel, write_sel;
  logic                  setup, access, ready_next;
  logic [PDATA_SIZE-1:0] new_word;
  logic                  unused_bits;

  assign setup   = PSEL && !PENABLE;
  assign access  = PSEL && PENABLE;
  assign offset  = PADDR - BASE_ADDR;
  assign idx_now = offset[LSB +: IDX_W];
  assign err_now = !addr_in_range(64'(PADDR), 64'(BASE_ADDR), SPAN)
                 || (|(PADDR & ALIGN_MASK))
                 || (REQ_PRIV && !PPROT[0]);

  // With zero wait states the response is produced at the setup edge itself,
  // so the live request is used then; otherwise the values latched at setup.
  assign idx_sel   = (state == IDLE) ? idx_now : idx_r;
  assign err_sel   = (state == IDLE) ? err_now : err_r;
  assign write_sel = (state == IDLE) ? PWRITE  : write_r;

  assign unused_bits = ^{PPROT[2:1], offset};

  apb_strb_merge #(.DATA_W(PDATA_SIZE)) u_strb_merge (
    .old_word (mem[idx_r]),
    .PWDATA   (PWDATA),
    .PSTRB    (strb_r),
    .new_word (new_word)
  );

  always_comb begin
    state_next = state;
    ready_next = 1'b0;
    case (state)
      IDLE: begin
        if (setup) begin
          if (wait_cfg == '0) begin
            state_next = DONE;
            ready_next = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (!PSEL) begin
          state_next = IDLE;
        end else if (PENABLE && cnt == WAIT_W'(1)) begin
          state_next = DONE;
          ready_next = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!PRESETn) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_r   <= '0;
      write_r <= 1'b0;
      strb_r  <= '0;
      err_r   <= 1'b0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
      err_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state   <= state_next;
      PREADY  <= ready_next;
      PSLVERR <= ready_next && err_sel;
      PRDATA  <= (ready_next && !err_sel && !write_sel) ? mem[idx_sel] : '0;

      if (state == IDLE && setup) begin
        cnt     <= wait_cfg;
        idx_r   <= idx_now;
        write_r <= PWRITE;
        strb_r  <= PSTRB;
        err_r   <= err_now;
      end else if (state == WAIT && access) begin
        cnt <= cnt - WAIT_W'(1);
      end

      if (state == DONE) begin
        if (err_r) begin
          if (err_cnt != '1) err_cnt <= err_cnt + ERRCNT_W'(1);
        end else if (write_r) begin
          mem[idx_r] <= new_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: hand-computed vectors covering transfers,
// strobes, wait states, error responses, abort, reset and counter saturation.
module tb_apb_slave_mem;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [2:0]  PRIV = 3'b001;

  logic        pclk     = 1'b0;
  logic        PRESETn  = 1'b0;
  logic        PSEL     = 1'b0;
  logic        PENABLE  = 1'b0;
  logic [2:0]  PPROT    = PRIV;
  logic        PWRITE   = 1'b0;
  logic [3:0]  PSTRB    = 4'h0;
  logic [31:0] PADDR    = '0;
  logic [31:0] PWDATA   = '0;
  logic [3:0]  wait_cfg = 4'h0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [7:0]  err_cnt;

  int vectors     = 0;
  int miscompares = 0;

  always #5 pclk = ~pclk;

  apb_slave_mem #(
    .PADDR_SIZE (32),
    .PDATA_SIZE (32),
    .DEPTH      (16),
    .BASE_ADDR  (BASE),
    .WAIT_W     (4),
    .REQ_PRIV   (1'b1),
    .ERRCNT_W   (8)
  ) dut (
    .pclk     (pclk),
    .PRESETn  (PRESETn),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PPROT    (PPROT),
    .PWRITE   (PWRITE),
    .PSTRB    (PSTRB),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
    .wait_cfg (wait_cfg),
    .err_cnt  (err_cnt)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full transfer; wait_cfg is scrambled after setup to show it is only sampled there.
  task automatic applyStimulus(input string tag, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb,
                               input logic [2:0] prot, input logic [3:0] wcfg,
                               output logic [31:0] rdata, output logic err, output int nacc);
    @(posedge pclk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
    PWDATA = data; PSTRB = strb; PPROT = prot; wait_cfg = wcfg;
    @(posedge pclk); #1;
    PENABLE = 1'b1; wait_cfg = 4'h0; nacc = 1;
    while (!PREADY && nacc < 40) begin
      @(posedge pclk); #1;
      nacc++;
    end
    rdata = PRDATA;
    err   = PSLVERR;
    checkOutput({tag, "_pready"}, PREADY, 1);
  endtask

  task automatic doRead(input string tag, input logic [31:0] addr, input logic [2:0] prot,
                        input logic [3:0] wcfg, input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          n;
    applyStimulus(tag, 1'b0, addr, 32'h0, 4'h0, prot, wcfg, rd, er, n);
    checkOutput({tag, "_data"}, rd, exp_data);
    checkOutput({tag, "_slverr"}, er, exp_err);
    checkOutput({tag, "_cycles"}, n, wcfg + 1);
  endtask

  task automatic doWrite(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [2:0] prot, input logic [3:0] wcfg,
                         input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          n;
    applyStimulus(tag, 1'b1, addr, data, strb, prot, wcfg, rd, er, n);
    checkOutput({tag, "_slverr"}, er, exp_err);
    checkOutput({tag, "_cycles"}, n, wcfg + 1);
  endtask

  task automatic idleCycle();
    @(posedge pclk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          n;

    repeat (3) @(posedge pclk);
    #1;
    checkOutput("rst_pready", PREADY, 0);
    checkOutput("rst_pslverr", PSLVERR, 0);
    checkOutput("rst_prdata", PRDATA, 0);
    checkOutput("rst_errcnt", err_cnt, 0);
    PRESETn = 1'b1;
    doRead("rst_mem", BASE + 32'h8, PRIV, 4'd0, 32'h0, 1'b0);

    doWrite("wr_dead", BASE + 32'h8, 32'hDEAD_BEEF, 4'hF, PRIV, 4'd0, 1'b0);
    doRead("rd_dead", BASE + 32'h8, PRIV, 4'd0, 32'hDEAD_BEEF, 1'b0);

    doWrite("wr_pre", BASE + 32'hC, 32'h1122_3344, 4'hF, PRIV, 4'd0, 1'b0);
    doWrite("wr_strb", BASE + 32'hC, 32'hAABB_CCDD, 4'b0101, PRIV, 4'd0, 1'b0);
    doRead("rd_strb", BASE + 32'hC, PRIV, 4'd0, 32'h11BB_33DD, 1'b0);
    doWrite("wr_nostrb", BASE + 32'hC, 32'hFFFF_FFFF, 4'h0, PRIV, 4'd1, 1'b0);
    doRead("rd_nostrb", BASE + 32'hC, PRIV, 4'd0, 32'h11BB_33DD, 1'b0);

    doRead("rd_wait3", BASE + 32'h8, PRIV, 4'd3, 32'hDEAD_BEEF, 1'b0);
    idleCycle();
    checkOutput("wait3_drop", PREADY, 0);

    doRead("err_range", BASE + 32'h40, PRIV, 4'd0, 32'h0, 1'b1);
    idleCycle();
    checkOutput("err_cnt1", err_cnt, 1);
    doWrite("err_align", BASE + 32'hA, 32'h0, 4'hF, PRIV, 4'd0, 1'b1);
    idleCycle();
    checkOutput("err_cnt2", err_cnt, 2);
    doRead("align_keep", BASE + 32'h8, PRIV, 4'd0, 32'hDEAD_BEEF, 1'b0);
    doRead("err_priv_rd", BASE + 32'h0, 3'b000, 4'd1, 32'h0, 1'b1);
    doWrite("err_priv_wr", BASE + 32'h0, 32'h5, 4'hF, 3'b110, 4'd0, 1'b1);
    doRead("priv_keep", BASE + 32'h0, PRIV, 4'd0, 32'h0, 1'b0);
    idleCycle();
    checkOutput("err_cnt4", err_cnt, 4);

    doWrite("b2b_w0", BASE + 32'h10, 32'h0102_0304, 4'hF, PRIV, 4'd1, 1'b0);
    doWrite("b2b_w1", BASE + 32'h14, 32'hA5A5_A5A5, 4'hF, PRIV, 4'd0, 1'b0);
    doRead("b2b_r0", BASE + 32'h10, PRIV, 4'd2, 32'h0102_0304, 1'b0);
    doRead("b2b_r1", BASE + 32'h14, PRIV, 4'd0, 32'hA5A5_A5A5, 1'b0);
    idleCycle();

    @(posedge pclk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = BASE + 32'h10;
    PWDATA = 32'hFFFF_FFFF; PSTRB = 4'hF; PPROT = PRIV; wait_cfg = 4'd5;
    for (int i = 0; i < 2; i++) begin
      @(posedge pclk); #1;
      PENABLE = 1'b1;
      checkOutput("abort_busy", PREADY, 0);
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge pclk); #1;
      checkOutput("abort_quiet", PREADY, 0);
    end
    doRead("abort_keep", BASE + 32'h10, PRIV, 4'd0, 32'h0102_0304, 1'b0);
    idleCycle();
    checkOutput("abort_errcnt", err_cnt, 4);

    for (int i = 0; i < 251; i++)
      applyStimulus("sat", 1'b0, 32'h0000_2000, 32'h0, 4'h0, PRIV, 4'd0, rd, er, n);
    idleCycle();
    checkOutput("sat_255", err_cnt, 255);
    for (int i = 0; i < 45; i++)
      applyStimulus("sat_more", 1'b0, 32'h0000_2000, 32'h0, 4'h0, PRIV, 4'd0, rd, er, n);
    idleCycle();
    checkOutput("sat_hold", err_cnt, 255);

    @(posedge pclk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = BASE + 32'h14;
    PWDATA = 32'h1234_5678; PSTRB = 4'hF; PPROT = PRIV; wait_cfg = 4'd2;
    @(posedge pclk); #1;
    PENABLE = 1'b1;
    @(posedge pclk); #1;
    PRESETn = 1'b0;
    @(posedge pclk); #1;
    checkOutput("mid_rst_pready", PREADY, 0);
    checkOutput("mid_rst_pslverr", PSLVERR, 0);
    checkOutput("mid_rst_prdata", PRDATA, 0);
    checkOutput("mid_rst_errcnt", err_cnt, 0);
    PRESETn = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
    doRead("mid_rst_mem14", BASE + 32'h14, PRIV, 4'd0, 32'h0, 1'b0);
    doRead("mid_rst_mem8", BASE + 32'h8, PRIV, 4'd1, 32'h0, 1'b0);
    idleCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
